popcount_accum: RTL

// Parametrised population-count block for the PMOD switch inputs. Each input bit is

---
 rtl/popcount_accum.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/popcount_accum.sv
// Population count of synchronised, debounced input bits, with an optional
// saturating accumulator that adds the count on sample strobes.
module popcount_accum #(
    parameter int unsigned N_IN      = 8,
    parameter int unsigned DB_CYCLES = 3,
    parameter int unsigned ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  din,
    input  logic             mode,
    input  logic             sample,
    input  logic             clear,
    output logic [ACC_W-1:0] count,
    output logic             change,
    output logic             overflow
);

    // ACC_W must be at least PC_W so the live popcount fits in count.
    localparam int unsigned PC_W  = $clog2(N_IN + 1);
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [N_IN-1:0]  s1_d, s1_q;
    logic [N_IN-1:0]  s2_d, s2_q;
    logic [N_IN-1:0]  db;
    logic [PC_W-1:0]  pc_d, pc_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic             overflow_d, overflow_q;
    logic             change_d, change_q;
    logic [ACC_W:0]   acc_sum;

    // Two-stage synchroniser per input bit.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    if (DB_CYCLES == 0) begin : g_db_bypass
        assign db = s2_q;
    end else begin : g_db
        localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

        logic [N_IN-1:0]  db_d, db_q;
        logic [CNT_W-1:0] cnt_d [N_IN];
        logic [CNT_W-1:0] cnt_q [N_IN];

        // A bit flips only after DB_CYCLES consecutive mismatching edges.
        always_comb begin
            db_d = db_q;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_d[i] = '0;
                if (s2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CntLast) begin
                        db_d[i] = s2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_q <= '0;
                for (int i = 0; i < int'(N_IN); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                db_q <= db_d;
                for (int i = 0; i < int'(N_IN); i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        assign db = db_q;
    end

    always_comb begin
        pc_d = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pc_d = pc_d + PC_W'(db[i]);
        end
    end

    // Clear has priority over sample; sample is ignored in live mode.
    always_comb begin
        acc_sum    = {1'b0, acc_q} + (ACC_W + 1)'(pc_q);
        acc_d      = acc_q;
        overflow_d = overflow_q;
        if (clear) begin
            acc_d      = '0;
            overflow_d = 1'b0;
        end else if (mode && sample) begin
            if (acc_sum[ACC_W]) begin
                acc_d      = ACC_MAX;
                overflow_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // Pulse tracks only the value currently shown, so mode switches stay silent.
    always_comb begin
        if (mode) begin
            change_d = (acc_d != acc_q);
        end else begin
            change_d = (pc_d != pc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            change_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            change_q   <= change_d;
        end
    end

    always_comb begin
        count = mode ? acc_q : ACC_W'(pc_q);
    end

    assign change   = change_q;
    assign overflow = overflow_q;

endmodule
